adaptimer_reader: RTL

ADAPTIMER_READER -- requirements
Module: adaptimer_reader

---
 rtl/adaptimer_pkg.sv | 40 ++++
 rtl/adaptimer_reader.sv | 132 +++++++++++++
 2 files changed

// File: rtl/adaptimer_pkg.sv
// Shared definitions for the adaptive timer: register offsets, response codes,
// reader FSM states and STATUS word layout.
package adaptimer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMER_W = 64;
  localparam int unsigned RES_W   = 8;
  localparam int unsigned OFF_W   = 4;

  localparam logic [OFF_W-1:0] OFF_TIME_LO  = 4'h0;
  localparam logic [OFF_W-1:0] OFF_TIME_HI  = 4'h4;
  localparam logic [OFF_W-1:0] OFF_STATUS   = 4'h8;
  localparam logic [OFF_W-1:0] OFF_RD_COUNT = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STAT_RES_LSB      = 0;
  localparam int unsigned STAT_SAFE_RES_LSB = 8;
  localparam int unsigned STAT_TIMER_EN     = 16;
  localparam int unsigned STAT_SAFE_ACTIVE  = 17;
  localparam int unsigned STAT_SNAP_VALID   = 18;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Field order matches the STAT_* bit positions above, MSB first.
  typedef struct packed {
    logic [12:0]      rsvd;
    logic             snap_valid;
    logic             safe_active;
    logic             timer_en;
    logic [RES_W-1:0] safe_res;
    logic [RES_W-1:0] res;
  } status_t;

endpackage

// File: rtl/adaptimer_reader.sv
// AXI4-Lite read-only register window onto the adaptive timer, with a
// LO-then-HI snapshot so 64-bit reads are coherent.
module adaptimer_reader
  import adaptimer_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  s_axi_araddr,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [DATA_W-1:0]  s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  input  logic [TIMER_W-1:0] adaptimer,
  input  logic [RES_W-1:0]   resolution,
  input  logic [RES_W-1:0]   safe_resolution,
  input  logic               timer_en,
  input  logic               safe_active,
  output logic               rd_strobe
);

  state_t              state_q, state_d;
  logic                arready_d;
  logic                rvalid_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [1:0]          rresp_d;
  logic                strobe_d;
  logic [TIMER_W-1:0]  snap_q, snap_d;
  logic                snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                ar_hs;
  logic                addr_ok;
  logic [OFF_W-1:0]    offset;
  status_t             status_w;

  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign offset  = s_axi_araddr[OFF_W-1:0];
  // Anything past the last register (including upper address bits) errors out.
  assign addr_ok = (s_axi_araddr[1:0] == 2'b00) &&
                   (s_axi_araddr <= ADDR_W'(OFF_RD_COUNT));

  assign status_w = '{rsvd:        '0,
                      snap_valid:  snap_valid_q,
                      safe_active: safe_active,
                      timer_en:    timer_en,
                      safe_res:    safe_resolution,
                      res:         resolution};

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_INIT;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
      rd_strobe     <= 1'b0;
      snap_q        <= '0;
      snap_valid_q  <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rdata   <= rdata_d;
      s_axi_rresp   <= rresp_d;
      rd_strobe     <= strobe_d;
      snap_q        <= snap_d;
      snap_valid_q  <= snap_valid_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next state, read decode and side effects.
  always_comb begin
    state_d      = state_q;
    rvalid_d     = s_axi_rvalid;
    rdata_d      = s_axi_rdata;
    rresp_d      = s_axi_rresp;
    strobe_d     = 1'b0;
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (ar_hs) begin
          state_d  = ST_RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_OKAY;
          if (!addr_ok) begin
            rresp_d = RESP_SLVERR;
          end else begin
            case (offset)
              OFF_TIME_LO: begin
                rdata_d      = adaptimer[DATA_W-1:0];
                snap_d       = adaptimer;
                snap_valid_d = 1'b1;
                strobe_d     = 1'b1;
                cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
              end
              OFF_TIME_HI: begin
                rdata_d      = snap_valid_q ? snap_q[TIMER_W-1:DATA_W]
                                            : adaptimer[TIMER_W-1:DATA_W];
                snap_valid_d = 1'b0;
              end
              OFF_STATUS: rdata_d = status_w;
              default:    rdata_d = DATA_W'(cnt_q);
            endcase
          end
        end
      end
      ST_RESP: begin
        if (s_axi_rready) begin
          state_d  = ST_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    arready_d = (state_d == ST_IDLE);
  end

endmodule
